rbin_stream_gen: RTL and testbench

Transmitter side of the r-bin stream that feeds the per-theta histogram accumulator.
- For one fixed theta slice, takes drift-circle hits (x, y, drift radius) and computes the Legendre r-values r = x*cos + y*sin ± drift.
- Quantises each r-value into a 7-bit bin and emits two bin tokens per hit on an 8-bit TDATA/TVALID/TREADY stream.
- Sequences the accumulator's control pins per event: clear sweep, enable while streaming, drain.
- One instance per theta slice, upstream of the histogram/local-max block.

---
 rtl/lsf_rbin_pkg.sv | 41 ++++
 rtl/rbin_stream_gen_if.sv | 37 +++
 rtl/rbin_quantizer.sv | 125 ++++++++++++
 rtl/rbin_stream_gen.sv | 143 ++++++++++++++
 tb/tb_rbin_stream_gen.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsf_rbin_pkg.sv
// ============================================================================
// Module      : lsf_rbin_pkg
// Description : Shared types and constants for the r-bin stream generator:
//               FSM state encoding, bin token layout, histogram geometry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsf_rbin_pkg;

  localparam int         NBINS      = 128;
  localparam int         BIN_CENTER = 64;
  localparam int         FRAC       = 10;
  localparam logic [7:0] RBIN_OOR   = 8'h80;

  // Per-event sequencing of the accumulator control pins
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // One stream beat: out-of-range flag above a 7-bit bin index
  typedef struct packed {
    logic       oor;
    logic [6:0] bin;
  } rbin_tok_t;

  // Build an in-range token from a bin index
  function automatic rbin_tok_t make_tok(input logic [6:0] bin);
    rbin_tok_t t;
    t.oor = 1'b0;
    t.bin = bin;
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rbin_stream_gen_if.sv
// ============================================================================
// Module      : rbin_stream_gen_if
// Description : Hit input handshake plus r-bin token stream (TDATA/TVALID/
//               TREADY) between the hit source, the generator and the
//               histogram accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rbin_stream_gen_if #(
  parameter int XW = 16,
  parameter int DW = 12
);
  logic signed [XW-1:0] hit_x;
  logic signed [XW-1:0] hit_y;
  logic        [DW-1:0] hit_drift;
  logic                 hit_last;
  logic                 hit_vld;
  logic                 hit_rdy;
  logic         [7:0]   r_bin_V_TDATA;
  logic                 r_bin_V_TVALID;
  logic                 r_bin_V_TREADY;

  // Hit source / token sink side
  modport master (
    output hit_x, hit_y, hit_drift, hit_last, hit_vld, r_bin_V_TREADY,
    input  hit_rdy, r_bin_V_TDATA, r_bin_V_TVALID
  );

  // Generator side
  modport slave (
    input  hit_x, hit_y, hit_drift, hit_last, hit_vld, r_bin_V_TREADY,
    output hit_rdy, r_bin_V_TDATA, r_bin_V_TVALID
  );
endinterface

`default_nettype wire

// File: rtl/rbin_quantizer.sv
// ============================================================================
// Module      : rbin_quantizer
// Description : Three-stage registered pipeline: multiply x*cos / y*sin,
//               add +/- drift, floor-shift into a bin and range check.
//               Each loaded hit is replayed once so the +drift token is
//               followed by the -drift token. Whole pipeline freezes on stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rbin_quantizer #(
  parameter int XW         = 16,
  parameter int DW         = 12,
  parameter int CW         = 12,
  parameter int FRAC       = lsf_rbin_pkg::FRAC,
  parameter int BIN_SHIFT  = 2,
  parameter int BIN_CENTER = lsf_rbin_pkg::BIN_CENTER,
  parameter int NBINS      = lsf_rbin_pkg::NBINS
) (
  input  wire                  clk,
  input  wire                  rst_n,
  input  wire                  stall_i,
  input  wire                  load_i,
  input  wire signed [XW-1:0]  x_i,
  input  wire signed [XW-1:0]  y_i,
  input  wire        [DW-1:0]  drift_i,
  input  wire signed [CW-1:0]  cos_i,
  input  wire signed [CW-1:0]  sin_i,
  output logic                 phase_o,
  output logic                 pipe_busy_o,
  output logic       [7:0]     tdata_o,
  output logic                 tvalid_o
);
  import lsf_rbin_pkg::*;

  localparam int PW = XW + CW;
  localparam int AW = XW + CW + 1;
  localparam int SH = FRAC + BIN_SHIFT;
  localparam logic signed [AW-1:0] MAX_IDX = AW'(NBINS - 1);
  localparam logic signed [AW-1:0] CENTER  = AW'(BIN_CENTER);

  logic signed [PW-1:0] prod_x_q, prod_y_q;
  logic        [DW-1:0] drift_q;
  logic                 neg_q, v1_q;
  logic signed [AW-1:0] acc_q;
  logic                 v2_q;
  logic         [7:0]   tdata_q;
  logic                 tvalid_q;

  logic signed [PW-1:0] w_x_ext, w_y_ext, w_cos_ext, w_sin_ext;
  logic signed [AW-1:0] w_sum, w_drift, w_acc_d, w_sh, w_idx;
  logic                 w_oor;
  rbin_tok_t            w_tok;

  assign w_x_ext   = {{(PW-XW){x_i[XW-1]}}, x_i};
  assign w_y_ext   = {{(PW-XW){y_i[XW-1]}}, y_i};
  assign w_cos_ext = {{(PW-CW){cos_i[CW-1]}}, cos_i};
  assign w_sin_ext = {{(PW-CW){sin_i[CW-1]}}, sin_i};

  // Stage 1: register products on load, then replay the same hit with -drift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_x_q <= '0;
      prod_y_q <= '0;
      drift_q  <= '0;
      neg_q    <= 1'b0;
      v1_q     <= 1'b0;
    end else if (!stall_i) begin
      if (load_i) begin
        prod_x_q <= w_x_ext * w_cos_ext;
        prod_y_q <= w_y_ext * w_sin_ext;
        drift_q  <= drift_i;
        neg_q    <= 1'b0;
        v1_q     <= 1'b1;
      end else if (v1_q && !neg_q) begin
        neg_q    <= 1'b1;
      end else begin
        neg_q    <= 1'b0;
        v1_q     <= 1'b0;
      end
    end
  end

  // High while the +drift beat sits in stage 1: the replay slot is taken
  assign phase_o = v1_q & ~neg_q;

  assign w_sum   = {prod_x_q[PW-1], prod_x_q} + {prod_y_q[PW-1], prod_y_q};
  assign w_drift = {{(AW-DW-FRAC){1'b0}}, drift_q, {FRAC{1'b0}}};
  assign w_acc_d = neg_q ? (w_sum - w_drift) : (w_sum + w_drift);

  // Stage 2: full-width r-value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      v2_q  <= 1'b0;
    end else if (!stall_i) begin
      v2_q <= v1_q;
      if (v1_q) acc_q <= w_acc_d;
    end
  end

  // Arithmetic shift floors toward minus infinity for negative r
  assign w_sh  = acc_q >>> SH;
  assign w_idx = w_sh + CENTER;
  assign w_oor = w_idx[AW-1] || (w_idx > MAX_IDX);
  assign w_tok = w_oor ? rbin_tok_t'(RBIN_OOR) : make_tok(w_idx[6:0]);

  // Stage 3: registered stream output, held while the sink stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else if (!stall_i) begin
      tvalid_q <= v2_q;
      if (v2_q) tdata_q <= w_tok;
    end
  end

  assign tdata_o     = tdata_q;
  assign tvalid_o    = tvalid_q;
  assign pipe_busy_o = v1_q | v2_q | tvalid_q;

endmodule

`default_nettype wire

// File: rtl/rbin_stream_gen.sv
// ============================================================================
// Module      : rbin_stream_gen
// Description : Per-theta r-bin token source. Sequences the histogram
//               accumulator (clear sweep, enable, drain), accepts hits and
//               feeds them through the quantizer pipeline, two tokens per hit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rbin_stream_gen #(
  parameter int XW         = 16,
  parameter int DW         = 12,
  parameter int CW         = 12,
  parameter int FRAC       = lsf_rbin_pkg::FRAC,
  parameter int BIN_SHIFT  = 2,
  parameter int BIN_CENTER = lsf_rbin_pkg::BIN_CENTER,
  parameter int NBINS      = lsf_rbin_pkg::NBINS,
  parameter int DRAIN_WAIT = 4
) (
  input  wire                  clk,
  input  wire                  rst_n,
  input  wire                  start,
  input  wire signed [CW-1:0]  theta_cos,
  input  wire signed [CW-1:0]  theta_sin,
  output logic                 enable_V,
  output logic                 reset_rbins,
  output logic                 busy,
  output logic                 done,
  rbin_stream_gen_if.slave     s
);
  import lsf_rbin_pkg::*;

  // Counter is shared by the clear sweep and the drain wait
  localparam int CNT_W = $clog2(NBINS);

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic signed [CW-1:0]  cos_q, sin_q;
  logic                  enable_q, reset_rbins_q, busy_q, done_q;

  logic                  w_stall, w_phase, w_accept, w_hit_rdy;
  logic                  w_pipe_busy, w_tvalid;
  logic [7:0]            w_tdata;

  assign w_stall   = w_tvalid & ~s.r_bin_V_TREADY;
  assign w_hit_rdy = (state_q == ST_RUN) & ~w_phase & ~w_stall;
  assign w_accept  = s.hit_vld & w_hit_rdy;

  rbin_quantizer #(
    .XW         (XW),
    .DW         (DW),
    .CW         (CW),
    .FRAC       (FRAC),
    .BIN_SHIFT  (BIN_SHIFT),
    .BIN_CENTER (BIN_CENTER),
    .NBINS      (NBINS)
  ) u_quant (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_i     (w_stall),
    .load_i      (w_accept),
    .x_i         (s.hit_x),
    .y_i         (s.hit_y),
    .drift_i     (s.hit_drift),
    .cos_i       (cos_q),
    .sin_i       (sin_q),
    .phase_o     (w_phase),
    .pipe_busy_o (w_pipe_busy),
    .tdata_o     (w_tdata),
    .tvalid_o    (w_tvalid)
  );

  // Event sequencer with registered accumulator control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      cos_q         <= '0;
      sin_q         <= '0;
      enable_q      <= 1'b0;
      reset_rbins_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cos_q         <= theta_cos;
            sin_q         <= theta_sin;
            cnt_q         <= '0;
            reset_rbins_q <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (cnt_q == CNT_W'(NBINS - 1)) begin
            reset_rbins_q <= 1'b0;
            enable_q      <= 1'b1;
            state_q       <= ST_RUN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (w_accept && s.hit_last) begin
            cnt_q   <= '0;
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Settling time only starts once every token has left
          if (!w_pipe_busy) begin
            if (cnt_q == CNT_W'(DRAIN_WAIT - 1)) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          enable_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign enable_V         = enable_q;
  assign reset_rbins      = reset_rbins_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign s.hit_rdy        = w_hit_rdy;
  assign s.r_bin_V_TDATA  = w_tdata;
  assign s.r_bin_V_TVALID = w_tvalid;

endmodule

`default_nettype wire

// File: tb/tb_rbin_stream_gen.sv
// ============================================================================
// Module      : tb_rbin_stream_gen
// Description : Directed self-checking bench for rbin_stream_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rbin_stream_gen;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic signed [11:0] theta_cos = '0;
  logic signed [11:0] theta_sin = '0;
  logic               enable_V, reset_rbins, busy, done;

  rbin_stream_gen_if #(.XW(16), .DW(12)) bus ();

  rbin_stream_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .theta_cos   (theta_cos),
    .theta_sin   (theta_sin),
    .enable_V    (enable_V),
    .reset_rbins (reset_rbins),
    .busy        (busy),
    .done        (done),
    .s           (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] tok_q[$];
  int         tcyc_q[$];
  logic [7:0] exp_q[$];

  // Token sink: record every handshake with its cycle index
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.r_bin_V_TVALID && bus.r_bin_V_TREADY) begin
      tok_q.push_back(bus.r_bin_V_TDATA);
      tcyc_q.push_back(cyc);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed no end of stimulus, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: floor((x*c + y*s +/- d*2^10) / 2^12) + 64, range 0..127
  function automatic logic [7:0] ref_tok(input int x, input int y, input int d,
                                         input int c, input int s, input bit neg);
    longint acc, q;
    acc = longint'(x) * c + longint'(y) * s;
    acc = neg ? acc - longint'(d) * 1024 : acc + longint'(d) * 1024;
    q = acc / 4096;
    if ((acc % 4096) != 0 && acc < 0) q = q - 1;
    q = q + 64;
    if (q < 0 || q > 127) return 8'h80;
    return 8'(q);
  endfunction

  task automatic clear_logs();
    tok_q.delete();
    tcyc_q.delete();
    exp_q.delete();
  endtask

  task automatic start_event(input int c, input int s);
    int n = 0;
    theta_cos = 12'(c);
    theta_sin = 12'(s);
    start = 1'b1;
    tick();
    start = 1'b0;
    theta_cos = '0;
    theta_sin = '0;
    while (!(enable_V && !reset_rbins) && n < 300) begin
      tick();
      n++;
    end
    check("clear_end_reached", (n < 300) ? 1 : 0, 1);
  endtask

  task automatic send_hit(input int x, input int y, input int d, input bit last,
                          output int acc_cyc);
    int n = 0;
    bus.hit_x     = 16'(x);
    bus.hit_y     = 16'(y);
    bus.hit_drift = 12'(d);
    bus.hit_last  = last;
    bus.hit_vld   = 1'b1;
    #1;
    while (!bus.hit_rdy && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    acc_cyc = cyc;
    check("hit_accepted", (n < 50) ? 1 : 0, 1);
    @(posedge clk);
    #1;
    bus.hit_vld  = 1'b0;
    bus.hit_last = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    int n = 0;
    while (!done && n < 400) begin
      tick();
      n++;
    end
    dc = cyc;
    check("done_seen", (n < 400) ? 1 : 0, 1);
  endtask

  task automatic compare_tokens(input string tag);
    check({tag, "_count"}, tok_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tok_q.size(); i++)
      check(tag, {24'(i), tok_q[i]}, {24'(i), exp_q[i]});
  endtask

  initial begin
    int a0, a1, dc, n, bad, bad_rdy;
    int acc_c[10];
    logic [7:0] cap;

    bus.hit_x = '0; bus.hit_y = '0; bus.hit_drift = '0;
    bus.hit_last = 1'b0; bus.hit_vld = 1'b0; bus.r_bin_V_TREADY = 1'b1;

    // ---- Reset state
    repeat (3) tick();
    check("rst_enable",   enable_V, 0);
    check("rst_reset",    reset_rbins, 0);
    check("rst_busy",     busy, 0);
    check("rst_done",     done, 0);
    check("rst_tvalid",   bus.r_bin_V_TVALID, 0);
    check("rst_tdata",    bus.r_bin_V_TDATA, 0);
    check("rst_hit_rdy",  bus.hit_rdy, 0);
    rst_n = 1'b1;
    tick();
    check("idle_hit_rdy", bus.hit_rdy, 0);

    // ---- Clear sweep length
    clear_logs();
    theta_cos = 12'sd1024; theta_sin = '0; start = 1'b1;
    tick();
    start = 1'b0; theta_cos = '0;
    n = 0; bad = 0;
    while (reset_rbins && n < 300) begin
      if (enable_V) bad++;
      n++;
      tick();
    end
    check("clear_len",        n, 128);
    check("clear_enable_low", bad, 0);
    check("run_enable",       enable_V, 1);
    check("run_hit_rdy",      bus.hit_rdy, 1);
    check("run_busy",         busy, 1);

    // ---- Basic hit: x=100, drift=20
    send_hit(100, 0, 20, 1'b1, a0);
    check("phase1_rdy_low", bus.hit_rdy, 0);
    wait_done(dc);
    exp_q = '{8'h5E, 8'h54};
    compare_tokens("basic_tok");
    if (tcyc_q.size() == 2) begin
      check("lat_first",  tcyc_q[0] - a0, 3);
      check("lat_second", tcyc_q[1] - a0, 4);
      check("done_delay", dc - tcyc_q[1], 5);
    end else begin
      check("basic_tok_cycles", tcyc_q.size(), 2);
    end
    tick();
    check("post_done_pulse",  done, 0);
    check("post_done_enable", enable_V, 0);
    check("post_done_busy",   busy, 0);

    // ---- Range and flooring
    clear_logs();
    start_event(1024, 0);
    send_hit(400, 0, 0, 1'b0, a0);
    send_hit(-300, 0, 0, 1'b0, a0);
    send_hit(-3, 0, 0, 1'b1, a0);
    wait_done(dc);
    exp_q = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h3F, 8'h3F};
    compare_tokens("range_tok");
    tick();

    // ---- Backpressure: TREADY low for 5 cycles mid-stream
    clear_logs();
    start_event(1024, 0);
    send_hit(100, 0, 20, 1'b0, a0);
    send_hit(-50, 0, 8, 1'b0, a1);
    bus.r_bin_V_TREADY = 1'b0;
    #1;
    check("bp_tvalid_at_stall", bus.r_bin_V_TVALID, 1);
    cap = bus.r_bin_V_TDATA;
    bad = 0; bad_rdy = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.r_bin_V_TVALID !== 1'b1 || bus.r_bin_V_TDATA !== cap) bad++;
      if (bus.hit_rdy !== 1'b0) bad_rdy++;
      @(posedge clk);
      #2;
    end
    check("bp_hold",    bad, 0);
    check("bp_hit_rdy", bad_rdy, 0);
    bus.r_bin_V_TREADY = 1'b1;
    send_hit(10, 0, 100, 1'b1, a0);
    wait_done(dc);
    exp_q = '{8'h5E, 8'h54, 8'h35, 8'h31, 8'h5B, 8'h29};
    compare_tokens("bp_tok");
    tick();

    // ---- Throughput at 45 degrees, with a stray start during RUN
    clear_logs();
    start_event(724, 724);
    theta_cos = 12'sd100; start = 1'b1;
    tick();
    start = 1'b0; theta_cos = '0;
    tick();
    check("start_in_run_reset", reset_rbins, 0);
    check("start_in_run_enable", enable_V, 1);
    bad_rdy = 0;
    for (int i = 0; i < 10; i++) begin
      send_hit(37 * i - 150, 200 - 23 * i, 5 * i + 3, (i == 9), acc_c[i]);
      if (i < 9 && bus.hit_rdy !== 1'b0) bad_rdy++;
      exp_q.push_back(ref_tok(37 * i - 150, 200 - 23 * i, 5 * i + 3, 724, 724, 1'b0));
      exp_q.push_back(ref_tok(37 * i - 150, 200 - 23 * i, 5 * i + 3, 724, 724, 1'b1));
    end
    wait_done(dc);
    compare_tokens("tp_tok");
    check("tp_rdy_toggle", bad_rdy, 0);
    bad = 0;
    for (int i = 1; i < 10; i++) if (acc_c[i] - acc_c[i-1] != 2) bad++;
    check("tp_accept_spacing", bad, 0);
    bad = 0;
    for (int i = 1; i < tcyc_q.size(); i++) if (tcyc_q[i] - tcyc_q[i-1] != 1) bad++;
    check("tp_tokens_contiguous", bad, 0);
    tick();

    // ---- Reset mid-stream, then a clean event
    clear_logs();
    start_event(1024, 0);
    send_hit(100, 0, 20, 1'b0, a0);
    send_hit(-50, 0, 8, 1'b0, a1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid",  bus.r_bin_V_TVALID, 0);
    check("midrst_tdata",   bus.r_bin_V_TDATA, 0);
    check("midrst_enable",  enable_V, 0);
    check("midrst_reset",   reset_rbins, 0);
    check("midrst_busy",    busy, 0);
    check("midrst_hit_rdy", bus.hit_rdy, 0);
    tick();
    rst_n = 1'b1;
    clear_logs();
    repeat (10) tick();
    check("midrst_no_tokens", tok_q.size(), 0);
    start_event(1024, 0);
    send_hit(100, 0, 20, 1'b1, a0);
    wait_done(dc);
    exp_q = '{8'h5E, 8'h54};
    compare_tokens("post_rst_tok");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
